mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of mem_arbiter: two request ports (A, B) and the shared read-data return.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              rvalid_a;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory with RD_LAT-cycle read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic              cen,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] add,
  output logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] dout
);

  typedef enum logic [1:0] {IDLE, ACC, WAIT, RESP} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t            state_q;
  logic              sel_b_q;
  logic              we_q;
  logic [1:0]        cnt_q;
  logic              gnt_a_q, gnt_b_q;
  logic              rvalid_a_q, rvalid_b_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cen_q, rd_q, wr_q;
  logic [ADDR_W-1:0] add_q;
  logic [DATA_W-1:0] din_q;

  logic              any_req_c;
  logic              pick_b_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign any_req_c = bus.req_a | bus.req_b;

`ifdef MEM_ARB_RR_EN
  // last_gnt_b_q = 1 means B was granted last, so A wins the next tie.
  logic last_gnt_b_q;

  assign pick_b_c = bus.req_b & (~bus.req_a | ~last_gnt_b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last_gnt_b_q <= 1'b1;
    else if (state_q == ACC)  last_gnt_b_q <= sel_b_q;
  end
`else
  assign pick_b_c = bus.req_b & ~bus.req_a;
`endif

  assign we_c    = pick_b_c ? bus.we_b    : bus.we_a;
  assign addr_c  = pick_b_c ? bus.addr_b  : bus.addr_a;
  assign wdata_c = pick_b_c ? bus.wdata_b : bus.wdata_a;

  // Access FSM; memory strobes and handshake pulses are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_b_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 2'd0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_q    <= '0;
      cen_q      <= 1'b1;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      add_q      <= '0;
      din_q      <= '0;
    end else begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req_c) begin
            state_q <= ACC;
            sel_b_q <= pick_b_c;
            we_q    <= we_c;
            cen_q   <= 1'b0;
            wr_q    <= we_c;
            rd_q    <= ~we_c;
            add_q   <= addr_c;
            din_q   <= wdata_c;
            gnt_a_q <= ~pick_b_c;
            gnt_b_q <= pick_b_c;
          end
        end
        ACC: begin
          if (we_q) begin
            state_q <= IDLE;
            cen_q   <= 1'b1;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            add_q   <= '0;
            din_q   <= '0;
          end else begin
            state_q <= WAIT;
            cnt_q   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q    <= RESP;
            rdata_q    <= dout;
            cen_q      <= 1'b1;
            rd_q       <= 1'b0;
            add_q      <= '0;
            din_q      <= '0;
            rvalid_a_q <= ~sel_b_q;
            rvalid_b_q <= sel_b_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;
  assign bus.rdata    = rdata_q;
  assign cen          = cen_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign add          = add_q;
  assign din          = din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3, each with a memory model.
module tb_mem_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk, rst, sel3;
  int   tests, fails;

  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

  logic          cen0, rd0, wr0, cen3, rd3, wr3;
  logic [AW-1:0] add0, add3;
  logic [DW-1:0] din0, din3, dout0, dout3;
  logic [DW-1:0] mem0 [0:4095];
  logic [DW-1:0] mem3 [0:4095];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .bus(if0.slave),
    .cen(cen0), .rd(rd0), .wr(wr0), .add(add0), .din(din0), .dout(dout0));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(if3.slave),
    .cen(cen3), .rd(rd3), .wr(wr3), .add(add3), .din(din3), .dout(dout3));

  assign if0.req_a   = req_a & ~sel3;
  assign if0.req_b   = req_b & ~sel3;
  assign if3.req_a   = req_a & sel3;
  assign if3.req_b   = req_b & sel3;
  assign if0.we_a    = we_a;    assign if3.we_a    = we_a;
  assign if0.we_b    = we_b;    assign if3.we_b    = we_b;
  assign if0.addr_a  = addr_a;  assign if3.addr_a  = addr_a;
  assign if0.addr_b  = addr_b;  assign if3.addr_b  = addr_b;
  assign if0.wdata_a = wdata_a; assign if3.wdata_a = wdata_a;
  assign if0.wdata_b = wdata_b; assign if3.wdata_b = wdata_b;

  // Memory models: asynchronous read, write on the edge that ends a write access.
  assign dout0 = mem0[add0];
  assign dout3 = mem3[add3];
  always @(posedge clk) if (!cen0 && wr0) mem0[add0] <= din0;
  always @(posedge clk) if (!cen3 && wr3) mem3[add3] <= din3;

  logic          s_gnt_a, s_gnt_b, s_rv_a, s_rv_b, s_cen, s_rd, s_wr;
  logic [AW-1:0] s_add;
  logic [DW-1:0] s_din, s_rdata;
  assign s_gnt_a = sel3 ? if3.gnt_a    : if0.gnt_a;
  assign s_gnt_b = sel3 ? if3.gnt_b    : if0.gnt_b;
  assign s_rv_a  = sel3 ? if3.rvalid_a : if0.rvalid_a;
  assign s_rv_b  = sel3 ? if3.rvalid_b : if0.rvalid_b;
  assign s_rdata = sel3 ? if3.rdata    : if0.rdata;
  assign s_cen   = sel3 ? cen3 : cen0;
  assign s_rd    = sel3 ? rd3  : rd0;
  assign s_wr    = sel3 ? wr3  : wr0;
  assign s_add   = sel3 ? add3 : add0;
  assign s_din   = sel3 ? din3 : din0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exclusivity properties on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if ((if0.gnt_a & if0.gnt_b) | (rd0 & wr0) | ((rd0 | wr0) & cen0) | (if0.rvalid_a & if0.rvalid_b)) begin
        fails++;
        $display("FAIL excl_u0 t=%0t gnt=%b%b rv=%b%b rd=%b wr=%b cen=%b, required one-hot gnt/rvalid/strobe with cen=0", $time, if0.gnt_a, if0.gnt_b, if0.rvalid_a, if0.rvalid_b, rd0, wr0, cen0);
      end
      tests++;
      if ((if3.gnt_a & if3.gnt_b) | (rd3 & wr3) | ((rd3 | wr3) & cen3) | (if3.rvalid_a & if3.rvalid_b)) begin
        fails++;
        $display("FAIL excl_u3 t=%0t gnt=%b%b rv=%b%b rd=%b wr=%b cen=%b, required one-hot gnt/rvalid/strobe with cen=0", $time, if3.gnt_a, if3.gnt_b, if3.rvalid_a, if3.rvalid_b, rd3, wr3, cen3);
      end
    end
  end

  // Drives one access; cycle 1 is the IDLE cycle that sees req. Returns observations only.
  task automatic access(input bit pb, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int gcyc, output int rcyc, output logic [DW-1:0] rdat, output bit other_rv,
                        output logic [AW-1:0] g_add, output logic [DW-1:0] g_din, output logic g_wr,
                        output logic g_rd, output logic post_wr, output logic post_cen, output int rd_cycles);
    gcyc = -1; rcyc = -1; rdat = '0; other_rv = 1'b0; g_add = '0; g_din = '0;
    g_wr = 1'b0; g_rd = 1'b0; post_wr = 1'b1; post_cen = 1'b0; rd_cycles = 0;
    @(posedge clk); #1;
    if (pb) begin req_b = 1'b1; we_b = we; addr_b = a; wdata_b = d; end
    else    begin req_a = 1'b1; we_a = we; addr_a = a; wdata_a = d; end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (s_rd && !s_cen) rd_cycles++;
      if (pb ? s_rv_a : s_rv_b) other_rv = 1'b1;
      if (gcyc >= 0 && cyc == gcyc + 1) begin post_wr = s_wr; post_cen = s_cen; end
      if ((pb ? s_gnt_b : s_gnt_a) && gcyc < 0) begin
        gcyc = cyc; g_add = s_add; g_din = s_din; g_wr = s_wr; g_rd = s_rd;
        if (pb) req_b = 1'b0; else req_a = 1'b0;
      end
      if ((pb ? s_rv_b : s_rv_a) && rcyc < 0) begin rcyc = cyc; rdat = s_rdata; end
      if (we ? (gcyc >= 0 && cyc == gcyc + 1) : (rcyc >= 0)) break;
    end
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if ({cen0, rd0, wr0} !== 3'b100) begin fails++; $display("FAIL rst_strobes cen/rd/wr=%b exp 100", {cen0, rd0, wr0}); end
    tests++; if ({add0, din0} !== '0) begin fails++; $display("FAIL rst_bus add=%h din=%h exp 0/0", add0, din0); end
    tests++; if ({if0.gnt_a, if0.gnt_b, if0.rvalid_a, if0.rvalid_b, if0.rdata} !== '0) begin
      fails++; $display("FAIL rst_hs gnt=%b%b rv=%b%b rdata=%h exp all 0", if0.gnt_a, if0.gnt_b, if0.rvalid_a, if0.rvalid_b, if0.rdata); end
    tests++; if (cen3 !== 1'b1) begin fails++; $display("FAIL rst_cen_u3 got %b exp 1", cen3); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (cen0 !== 1'b1) begin fails++; $display("FAIL idle_cen got %b exp 1", cen0); end
  endtask

  task automatic test_write_read_a();
    int gc, rc, nrd; logic [DW-1:0] rdat, gdin; logic [AW-1:0] gadd; bit oth; logic gwr, grd, pwr, pcen;
    access(1'b0, 1'b1, 12'h3AA, 8'hAA, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if (gc !== 2) begin fails++; $display("FAIL wa_gnt_cyc got %0d exp 2", gc); end
    tests++; if ({gwr, grd, gadd, gdin} !== {1'b1, 1'b0, 12'h3AA, 8'hAA}) begin
      fails++; $display("FAIL wa_acc wr=%b rd=%b add=%h din=%h exp 1/0/3aa/aa", gwr, grd, gadd, gdin); end
    tests++; if ({pwr, pcen} !== 2'b01) begin fails++; $display("FAIL wa_one_cycle wr=%b cen=%b exp 0/1", pwr, pcen); end
    access(1'b0, 1'b0, 12'h3AA, 8'h00, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if ({grd, gwr, gadd} !== {1'b1, 1'b0, 12'h3AA}) begin fails++; $display("FAIL ra_acc rd=%b wr=%b add=%h exp 1/0/3aa", grd, gwr, gadd); end
    tests++; if (rc !== 4) begin fails++; $display("FAIL ra_latency got cycle %0d exp 4", rc); end
    tests++; if (rdat !== 8'hAA) begin fails++; $display("FAIL ra_rdata got %h exp aa", rdat); end
    tests++; if (nrd !== 2) begin fails++; $display("FAIL ra_rd_cycles got %0d exp 2", nrd); end
  endtask

  task automatic test_b_then_a();
    int gc, rc, nrd; logic [DW-1:0] rdat, gdin; logic [AW-1:0] gadd; bit oth; logic gwr, grd, pwr, pcen;
    access(1'b1, 1'b1, 12'h3AB, 8'hBB, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if ({gc == 2, gwr, gadd, gdin} !== {1'b1, 1'b1, 12'h3AB, 8'hBB}) begin
      fails++; $display("FAIL wb_acc gcyc=%0d wr=%b add=%h din=%h exp 2/1/3ab/bb", gc, gwr, gadd, gdin); end
    access(1'b0, 1'b0, 12'h3AB, 8'h00, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if ({rc == 4, rdat} !== {1'b1, 8'hBB}) begin fails++; $display("FAIL ra_3ab cycle=%0d rdata=%h exp 4/bb", rc, rdat); end
    tests++; if (oth !== 1'b0) begin fails++; $display("FAIL ra_3ab_rvb got rvalid_b=%b exp 0", oth); end
    @(negedge clk);
    tests++; if ({s_rv_a, s_rdata} !== {1'b0, 8'hBB}) begin fails++; $display("FAIL rdata_hold rv=%b rdata=%h exp 0/bb", s_rv_a, s_rdata); end
    access(1'b0, 1'b0, 12'h3CD, 8'h00, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if ({rc == 4, oth} !== 2'b10) begin fails++; $display("FAIL ra_3cd cycle=%0d rvalid_b=%b exp 4/0", rc, oth); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 12'h3AA;
    @(negedge clk);
    @(negedge clk);
    tests++; if (s_gnt_a !== 1'b1) begin fails++; $display("FAIL mw_gnt got %b exp 1", s_gnt_a); end
    req_a = 1'b0;
    @(posedge clk); #2;
    tests++; if ({s_rd, s_cen} !== 2'b10) begin fails++; $display("FAIL mw_in_wait rd=%b cen=%b exp 1/0", s_rd, s_cen); end
    rst = 1'b1;
    #1;
    tests++; if ({s_cen, s_rd, s_rv_a} !== 3'b100) begin fails++; $display("FAIL mw_rst_now cen=%b rd=%b rv=%b exp 1/0/0", s_cen, s_rd, s_rv_a); end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (s_rv_a | s_gnt_a | s_rv_b | s_gnt_b) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mw_no_resp got activity=%b exp 0", seen); end
  endtask

  task automatic test_arbitration();
    logic gseq [4];
    logic expb;
    int   ng;
    ng = 0;
    for (int i = 0; i < 4; i++) gseq[i] = 1'bx;
    @(posedge clk); #1;
    req_a = 1'b1; we_a = 1'b1; addr_a = 12'h100; wdata_a = 8'h11;
    req_b = 1'b1; we_b = 1'b1; addr_b = 12'h200; wdata_b = 8'h22;
    repeat (8) begin
      @(negedge clk);
      if (s_gnt_a | s_gnt_b) begin if (ng < 4) gseq[ng] = s_gnt_b; ng++; end
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (ng !== 4) begin fails++; $display("FAIL arb_count got %0d grants exp 4", ng); end
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      expb = (i % 2) == 1;
`else
      expb = 1'b0;
`endif
      tests++; if (gseq[i] !== expb) begin fails++; $display("FAIL arb_seq%0d got B=%b exp B=%b", i, gseq[i], expb); end
    end
  endtask

  task automatic test_rdlat3();
    int gc, rc, nrd; logic [DW-1:0] rdat, gdin; logic [AW-1:0] gadd; bit oth; logic gwr, grd, pwr, pcen;
    sel3 = 1'b1;
    access(1'b1, 1'b1, 12'h3AB, 8'hBB, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if (gc !== 2) begin fails++; $display("FAIL l3_wb_gnt got %0d exp 2", gc); end
    access(1'b0, 1'b0, 12'h3AB, 8'h00, gc, rc, rdat, oth, gadd, gdin, gwr, grd, pwr, pcen, nrd);
    tests++; if (nrd !== 4) begin fails++; $display("FAIL l3_rd_cycles got %0d exp 4", nrd); end
    tests++; if (rc !== 6) begin fails++; $display("FAIL l3_latency got cycle %0d exp 6", rc); end
    tests++; if (rdat !== 8'hBB) begin fails++; $display("FAIL l3_rdata got %h exp bb", rdat); end
    @(posedge clk); #1 sel3 = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    sel3 = 1'b0; rst = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    #1 rst = 1'b1;
    test_reset();
    test_write_read_a();
    test_b_then_a();
    test_reset_mid_wait();
    test_arbitration();
    test_rdlat3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
